clock24_counter: RTL and testbench
==================================

CLOCK24_COUNTER -- requirements
Module: clock24_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, clk cycles per second tick.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port run_i  input  1  1 = timekeeping advances, 0 = time frozen.
REQ-005 SHALL have port load_i  input  1  single-cycle strobe to load hours_i/mins_i/secs_i.
REQ-006 SHALL have port hours_i  input  5  hours to load, binary 0-23.
REQ-007 SHALL have port mins_i  input  6  minutes to load, binary 0-59.
REQ-008 SHALL have port secs_i  input  6  seconds to load, binary 0-59.
REQ-009 SHALL have port hours_o  output  5  current hours, binary.
REQ-010 SHALL have port mins_o  output  6  current minutes, binary.
REQ-011 SHALL have port secs_o  output  6  current seconds, binary.
REQ-012 SHALL have ports hours_bcd_o, mins_bcd_o, secs_bcd_o  output  8 each  two-digit BCD of current time, tens in [7:4].
REQ-013 SHALL have port sec_pulse_o  output  1  one-cycle pulse when seconds advance.
REQ-014 SHALL have port day_wrap_o  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.
REQ-015 SHALL have port load_err_o  output  1  one-cycle pulse on rejected load.

Function
REQ-016 Prescaler SHALL count 0..CLK_HZ-1 while run_i=1 and hold its value while run_i=0; tick = prescaler at CLK_HZ-1 and run_i=1.
REQ-017 On tick, prescaler SHALL return to 0 and time SHALL advance by one second on the next edge.
REQ-018 Seconds SHALL wrap 59->0 with minute carry; minutes 59->0 with hour carry; hours 23->0.
REQ-019 sec_pulse_o SHALL be registered, high exactly the cycle the new seconds value first appears on secs_o.
REQ-020 day_wrap_o SHALL be high in the same cycle as sec_pulse_o when time becomes 00:00:00 through counting, never on load.
REQ-021 Load SHALL be valid iff hours_i<=23, mins_i<=59, secs_i<=59.
REQ-022 Valid load SHALL update hours_o/mins_o/secs_o one cycle after load_i and clear the prescaler to 0.
REQ-023 Invalid load SHALL leave time and prescaler unchanged and pulse load_err_o one cycle after load_i.
REQ-024 Load SHALL take priority over a tick in the same cycle; the tick is discarded; sec_pulse_o and day_wrap_o stay 0.
REQ-025 Load SHALL be accepted regardless of run_i.
REQ-026 BCD outputs SHALL be combinational from the binary registers (same cycle as binary outputs).
REQ-027 Holding load_i high SHALL reload every cycle (prescaler held at 0).

Reset
REQ-028 While rst_n=0 at clk edge: time = 00:00:00, prescaler = 0, sec_pulse_o = day_wrap_o = load_err_o = 0; BCD outputs = 8'h00.
REQ-029 rst_n SHALL override load_i and tick in the same cycle; reset mid-count discards partial second.

Structure
REQ-030 Shared package SHALL hold constants MAX_HOURS=23, MAX_MINS=59, MAX_SECS=59 and field widths 5/6/6, also used by the time-setter.
REQ-031 Binary-to-BCD conversion (6-bit in, 8-bit out, 0-59) SHALL be one sub-module, bin2bcd_60, instantiated three times.
REQ-032 Prescaler width SHALL be $clog2(CLK_HZ); CLK_HZ=1 SHALL tick every cycle while run_i=1.

Verification (CLK_HZ=4)
REQ-033 Reset, run_i=1 for 8 cycles -> secs_o 0->1->2, sec_pulse_o each 4th cycle, hours/mins 0.
REQ-034 Load 23:59:58, run 8 cycles -> 23:59:59 then 00:00:00 with day_wrap_o=1 one cycle; BCD 8'h23,8'h59,8'h59 then 8'h00 x3.
REQ-035 Load 24:00:00 and 12:60:00 -> load_err_o pulses, time unchanged.
REQ-036 Load 10:20:30 coincident with tick -> 10:20:30 next cycle, sec_pulse_o=0, next advance 4 cycles later.
REQ-037 run_i=0 at prescaler=2 for 10 cycles -> time frozen; resume -> advance after 1 more cycle.
REQ-038 rst_n=0 during load_i=1 at 05:05:05 -> 00:00:00, load_err_o=0.

Source files
------------

// File: rtl/clock24_counter_pkg.sv
// Shared time-of-day limits and field widths for the 24-hour clock and its time-setter.
package clock24_counter_pkg;

  localparam int unsigned HOURS_W = 5;
  localparam int unsigned MINS_W  = 6;
  localparam int unsigned SECS_W  = 6;

  localparam logic [HOURS_W-1:0] MAX_HOURS = 5'd23;
  localparam logic [MINS_W-1:0]  MAX_MINS  = 6'd59;
  localparam logic [SECS_W-1:0]  MAX_SECS  = 6'd59;

  // A load is accepted only when every field is a legal time-of-day value.
  function automatic logic load_valid(input logic [HOURS_W-1:0] h,
                                      input logic [MINS_W-1:0]  m,
                                      input logic [SECS_W-1:0]  s);
    return (h <= MAX_HOURS) && (m <= MAX_MINS) && (s <= MAX_SECS);
  endfunction

endpackage

// File: rtl/clock24_counter_bin2bcd_60.sv
// Two-digit BCD conversion for binary values 0-59 (tens digit in [7:4]).
module bin2bcd_60 (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  logic [3:0] tens_s;
  logic [3:0] ones_s;

  // Subtract the largest multiple of ten not exceeding the input.
  always_comb begin
    tens_s = 4'd0;
    ones_s = 4'd0;
    if (bin >= 6'd50) begin
      tens_s = 4'd5;
      ones_s = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens_s = 4'd4;
      ones_s = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens_s = 4'd3;
      ones_s = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens_s = 4'd2;
      ones_s = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens_s = 4'd1;
      ones_s = 4'(bin - 6'd10);
    end else begin
      tens_s = 4'd0;
      ones_s = 4'(bin);
    end
  end

  assign bcd = {tens_s, ones_s};

endmodule

// File: rtl/clock24_counter.sv
// 24-hour time-of-day counter with one-second prescaler, validated load and BCD views.
module clock24_counter
  import clock24_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               load_i,
  input  logic [HOURS_W-1:0] hours_i,
  input  logic [MINS_W-1:0]  mins_i,
  input  logic [SECS_W-1:0]  secs_i,
  output logic [HOURS_W-1:0] hours_o,
  output logic [MINS_W-1:0]  mins_o,
  output logic [SECS_W-1:0]  secs_o,
  output logic [7:0]         hours_bcd_o,
  output logic [7:0]         mins_bcd_o,
  output logic [7:0]         secs_bcd_o,
  output logic               sec_pulse_o,
  output logic               day_wrap_o,
  output logic               load_err_o
);

  // A one-cycle-per-second clock still needs a 1-bit prescaler register.
  localparam int unsigned    PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0]   pre_r;
  logic [HOURS_W-1:0] hours_r;
  logic [MINS_W-1:0]  mins_r;
  logic [SECS_W-1:0]  secs_r;
  logic               sec_pulse_r;
  logic               day_wrap_r;
  logic               load_err_r;

  logic               tick_s;
  logic               day_end_s;
  logic [HOURS_W-1:0] nxt_hours_s;
  logic [MINS_W-1:0]  nxt_mins_s;
  logic [SECS_W-1:0]  nxt_secs_s;

  assign tick_s = run_i && (pre_r == PRE_MAX);

  // Time one second from now, with carries through minutes and hours.
  always_comb begin
    nxt_hours_s = hours_r;
    nxt_mins_s  = mins_r;
    nxt_secs_s  = secs_r;
    day_end_s   = 1'b0;
    if (secs_r == MAX_SECS) begin
      nxt_secs_s = 6'd0;
      if (mins_r == MAX_MINS) begin
        nxt_mins_s = 6'd0;
        if (hours_r == MAX_HOURS) begin
          nxt_hours_s = 5'd0;
          day_end_s   = 1'b1;
        end else begin
          nxt_hours_s = hours_r + 5'd1;
        end
      end else begin
        nxt_mins_s = mins_r + 6'd1;
      end
    end else begin
      nxt_secs_s = secs_r + 6'd1;
    end
  end

  // Timekeeping state; a load (valid or not) swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_r       <= {PRE_W{1'b0}};
      hours_r     <= 5'd0;
      mins_r      <= 6'd0;
      secs_r      <= 6'd0;
      sec_pulse_r <= 1'b0;
      day_wrap_r  <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      sec_pulse_r <= 1'b0;
      day_wrap_r  <= 1'b0;
      load_err_r  <= 1'b0;
      if (load_i) begin
        if (load_valid(hours_i, mins_i, secs_i)) begin
          hours_r <= hours_i;
          mins_r  <= mins_i;
          secs_r  <= secs_i;
          pre_r   <= {PRE_W{1'b0}};
        end else begin
          load_err_r <= 1'b1;
        end
      end else if (tick_s) begin
        pre_r       <= {PRE_W{1'b0}};
        hours_r     <= nxt_hours_s;
        mins_r      <= nxt_mins_s;
        secs_r      <= nxt_secs_s;
        sec_pulse_r <= 1'b1;
        day_wrap_r  <= day_end_s;
      end else if (run_i) begin
        pre_r <= pre_r + PRE_W'(1);
      end else begin
        pre_r <= pre_r;
      end
    end
  end

  assign hours_o     = hours_r;
  assign mins_o      = mins_r;
  assign secs_o      = secs_r;
  assign sec_pulse_o = sec_pulse_r;
  assign day_wrap_o  = day_wrap_r;
  assign load_err_o  = load_err_r;

  bin2bcd_60 u_hours_bcd (.bin({1'b0, hours_r}), .bcd(hours_bcd_o));
  bin2bcd_60 u_mins_bcd  (.bin(mins_r),          .bcd(mins_bcd_o));
  bin2bcd_60 u_secs_bcd  (.bin(secs_r),          .bcd(secs_bcd_o));

endmodule

// File: tb/tb_clock24_counter.sv
// Directed bench for clock24_counter at CLK_HZ=4, checked each cycle against a seconds-of-day model.
module tb_clock24_counter;

  localparam int unsigned CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_i;
  logic       load_i;
  logic [4:0] hours_i;
  logic [5:0] mins_i;
  logic [5:0] secs_i;
  logic [4:0] hours_o;
  logic [5:0] mins_o;
  logic [5:0] secs_o;
  logic [7:0] hours_bcd_o;
  logic [7:0] mins_bcd_o;
  logic [7:0] secs_bcd_o;
  logic       sec_pulse_o;
  logic       day_wrap_o;
  logic       load_err_o;

  int n_vec  = 0;
  int n_miss = 0;

  int m_t = 0;
  int m_pre = 0;
  bit m_pulse = 1'b0;
  bit m_wrap = 1'b0;
  bit m_err = 1'b0;
  bit model_valid = 1'b0;

  clock24_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .load_i(load_i),
    .hours_i(hours_i), .mins_i(mins_i), .secs_i(secs_i),
    .hours_o(hours_o), .mins_o(mins_o), .secs_o(secs_o),
    .hours_bcd_o(hours_bcd_o), .mins_bcd_o(mins_bcd_o), .secs_bcd_o(secs_bcd_o),
    .sec_pulse_o(sec_pulse_o), .day_wrap_o(day_wrap_o), .load_err_o(load_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Model: time held as seconds since midnight plus a cycle count within the second.
  always @(posedge clk) begin : model
    int t, p;
    bit pu, wr, er;
    t = m_t; p = m_pre; pu = 1'b0; wr = 1'b0; er = 1'b0;
    if (!rst_n) begin
      t = 0; p = 0;
    end else if (load_i) begin
      if (hours_i < 24 && mins_i < 60 && secs_i < 60) begin
        t = hours_i * 3600 + mins_i * 60 + secs_i;
        p = 0;
      end else begin
        er = 1'b1;
      end
    end else if (run_i) begin
      if (p == CLK_HZ - 1) begin
        p  = 0;
        t  = (t + 1) % 86400;
        pu = 1'b1;
        wr = (t == 0);
      end else begin
        p = p + 1;
      end
    end
    m_t <= t; m_pre <= p; m_pulse <= pu; m_wrap <= wr; m_err <= er;
    model_valid <= 1'b1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("hours", int'(hours_o), m_t / 3600);
      chk("mins", int'(mins_o), (m_t / 60) % 60);
      chk("secs", int'(secs_o), m_t % 60);
      chk("hours_bcd", int'(hours_bcd_o), to_bcd(m_t / 3600));
      chk("mins_bcd", int'(mins_bcd_o), to_bcd((m_t / 60) % 60));
      chk("secs_bcd", int'(secs_bcd_o), to_bcd(m_t % 60));
      chk("sec_pulse", int'(sec_pulse_o), int'(m_pulse));
      chk("day_wrap", int'(day_wrap_o), int'(m_wrap));
      chk("load_err", int'(load_err_o), int'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_load(input logic l, input int h, input int m, input int s);
    load_i  = l;
    hours_i = 5'(h);
    mins_i  = 6'(m);
    secs_i  = 6'(s);
  endtask

  initial begin
    rst_n = 1'b0; run_i = 1'b0;
    set_load(1'b0, 0, 0, 0);
    cyc(2);
    chk("lit_reset_secs", int'(secs_o), 0);
    chk("lit_reset_hbcd", int'(hours_bcd_o), 8'h00);

    // Free run from reset: one second every 4 cycles.
    rst_n = 1'b1; run_i = 1'b1;
    cyc(3);
    chk("lit_no_pulse_yet", int'(sec_pulse_o), 0);
    cyc(1);
    chk("lit_first_sec", int'(secs_o), 1);
    chk("lit_first_pulse", int'(sec_pulse_o), 1);
    cyc(4);
    chk("lit_second_sec", int'(secs_o), 2);

    // Day rollover from 23:59:58.
    set_load(1'b1, 23, 59, 58);
    cyc(1);
    set_load(1'b0, 0, 0, 0);
    chk("lit_load_hbcd", int'(hours_bcd_o), 8'h23);
    chk("lit_load_sbcd", int'(secs_bcd_o), 8'h58);
    cyc(4);
    chk("lit_59_sbcd", int'(secs_bcd_o), 8'h59);
    chk("lit_59_mbcd", int'(mins_bcd_o), 8'h59);
    cyc(4);
    chk("lit_wrap", int'(day_wrap_o), 1);
    chk("lit_wrap_hbcd", int'(hours_bcd_o), 8'h00);
    chk("lit_wrap_sbcd", int'(secs_bcd_o), 8'h00);
    cyc(1);
    chk("lit_wrap_once", int'(day_wrap_o), 0);

    // Rejected loads leave time alone.
    set_load(1'b1, 24, 0, 0);
    cyc(1);
    chk("lit_err_h24", int'(load_err_o), 1);
    set_load(1'b1, 12, 60, 0);
    cyc(1);
    chk("lit_err_m60", int'(load_err_o), 1);
    chk("lit_err_hours", int'(hours_o), 0);
    set_load(1'b0, 0, 0, 0);

    // Align a valid load with a tick (prescaler at 3 on the load edge).
    cyc(2);
    set_load(1'b1, 10, 20, 30);
    cyc(1);
    set_load(1'b0, 0, 0, 0);
    chk("lit_coinc_sbcd", int'(secs_bcd_o), 8'h30);
    chk("lit_coinc_pulse", int'(sec_pulse_o), 0);
    cyc(3);
    chk("lit_coinc_hold", int'(secs_o), 30);
    cyc(1);
    chk("lit_coinc_next", int'(secs_o), 31);

    // Freeze at prescaler 2, then resume.
    cyc(2);
    run_i = 1'b0;
    cyc(10);
    chk("lit_frozen", int'(secs_o), 31);
    run_i = 1'b1;
    cyc(1);
    chk("lit_resume_wait", int'(secs_o), 31);
    cyc(1);
    chk("lit_resume_adv", int'(secs_o), 32);

    // Load held high keeps reloading; counting resumes 4 cycles after release.
    set_load(1'b1, 1, 2, 3);
    cyc(6);
    set_load(1'b0, 0, 0, 0);
    chk("lit_hold_secs", int'(secs_o), 3);
    cyc(3);
    chk("lit_hold_wait", int'(secs_o), 3);
    cyc(1);
    chk("lit_hold_adv", int'(secs_o), 4);

    // Reset wins over a coincident load.
    rst_n = 1'b0;
    set_load(1'b1, 5, 5, 5);
    cyc(1);
    chk("lit_rst_hours", int'(hours_o), 0);
    chk("lit_rst_err", int'(load_err_o), 0);
    rst_n = 1'b1;
    set_load(1'b0, 0, 0, 0);
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
